// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
// Module      : genius_pkg
// Description : Shared definitions for the Genius memory-game controller:
//               state encodings, the default result-hold time, the
//               datapath command bundle and the state-to-command decode.
// Revision    : 1.0 - initial release
// ============================================================================
package genius_pkg;

    // State encodings also drive the debug LEDs, so the values are fixed.
    typedef enum logic [3:0] {
        ST_INIT       = 4'd0,
        ST_SETUP      = 4'd1,
        ST_PREP       = 4'd2,
        ST_PLAY_FPGA  = 4'd3,
        ST_PLAY_USER  = 4'd4,
        ST_CHECK      = 4'd5,
        ST_NEXT_ROUND = 4'd6,
        ST_WIN_CHECK  = 4'd7,
        ST_RESULT     = 4'd8
    } state_t;

    // One second at 50 MHz.
    localparam int C_HOLD_CYCLES_DEF = 50_000_000;
    localparam int C_HOLD_W_DEF      = 26;

    // Datapath command bundle.
    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    // Moore decode; anything not listed (including unused encodings) is all-zero.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_INIT:       begin c.r1 = 1'b1; c.r2 = 1'b1; end
            ST_SETUP:      c.e1  = 1'b1;
            ST_PREP:       c.r2  = 1'b1;
            ST_PLAY_FPGA:  c.e3  = 1'b1;
            ST_PLAY_USER:  c.e2  = 1'b1;
            ST_NEXT_ROUND: c.e4  = 1'b1;
            ST_RESULT:     c.sel = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/genius_controller_edge_detect_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_rise
// Description : 1-bit rising-edge detector. Keeps a registered copy of the
//               input and flags the cycle where the input is high and the
//               previous sample was low.
// Ports       : clk    - clock
//               rst    - synchronous active-high reset (clears the history)
//               i_d    - level input, already synchronised
//               o_rise - high while i_d is high and was low last cycle
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/genius_controller.sv
`default_nettype none
// ============================================================================
// Module      : genius_controller
// Description : Control FSM for the Genius memory game. Sequences setup,
//               FPGA playback, user entry, round check, round advance and
//               result display, and drives the datapath command lines.
// Ports       : clock_50  - 50 MHz system clock
//               reset     - synchronous active-high reset
//               enter     - start/confirm key level (synchronised)
//               end_fpga, end_user, end_time, win, match - datapath status
//               r1, r2    - datapath resets (global / per-round)
//               e1..e4    - datapath enables
//               sel       - display select (1 = result screen)
//               state     - current state encoding for debug LEDs
// Revision    : 1.0 - initial release
// ============================================================================
module genius_controller
    import genius_pkg::*;
#(
    parameter int HOLD_CYCLES = C_HOLD_CYCLES_DEF,
    parameter int HOLD_W      = C_HOLD_W_DEF
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_fpga,
    input  logic       end_user,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       r1,
    output logic       r2,
    output logic       e1,
    output logic       e2,
    output logic       e3,
    output logic       e4,
    output logic       sel,
    output logic [3:0] state
);

    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_CYCLES[HOLD_W-1:0];

    state_t            r_state;
    state_t            w_next;
    ctrl_t             r_ctrl;
    logic [HOLD_W-1:0] r_hold;
    logic              w_enter_rise;
    logic              w_hold_done;

    edge_detect_rise u_enter_edge (
        .clk    (clock_50),
        .rst    (reset),
        .i_d    (enter),
        .o_rise (w_enter_rise)
    );

    assign w_hold_done = (r_hold == C_HOLD_MAX);

    // Next-state logic. Status inputs only matter in the states that use them.
    always_comb begin
        w_next = ST_INIT;
        case (r_state)
            ST_INIT:       w_next = ST_SETUP;
            ST_SETUP:      w_next = w_enter_rise ? ST_PREP : ST_SETUP;
            ST_PREP:       w_next = ST_PLAY_FPGA;
            ST_PLAY_FPGA:  w_next = end_fpga ? ST_PLAY_USER : ST_PLAY_FPGA;
            ST_PLAY_USER: begin
                // Timeout wins over a simultaneous final entry.
                if (end_time) begin
                    w_next = ST_RESULT;
                end else if (end_user) begin
                    w_next = ST_CHECK;
                end else begin
                    w_next = ST_PLAY_USER;
                end
            end
            // match is sampled one cycle after end_user so the datapath settles.
            ST_CHECK:      w_next = match ? ST_NEXT_ROUND : ST_RESULT;
            ST_NEXT_ROUND: w_next = ST_WIN_CHECK;
            ST_WIN_CHECK:  w_next = win ? ST_RESULT : ST_PREP;
            // Presses before the hold expires are dropped, not remembered.
            ST_RESULT:     w_next = (w_hold_done && w_enter_rise) ? ST_INIT : ST_RESULT;
            default:       w_next = ST_INIT;
        endcase
    end

    // State and outputs are registered together; outputs are the decode of
    // the state being entered, so they always equal decode(r_state).
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_ctrl  <= decode_ctrl(ST_INIT);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
        end
    end

    // Result-screen hold timer: zero outside RESULT, saturating inside it.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_hold <= '0;
        end else if (r_state != ST_RESULT) begin
            r_hold <= '0;
        end else if (!w_hold_done) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign r1    = r_ctrl.r1;
    assign r2    = r_ctrl.r2;
    assign e1    = r_ctrl.e1;
    assign e2    = r_ctrl.e2;
    assign e3    = r_ctrl.e3;
    assign e4    = r_ctrl.e4;
    assign sel   = r_ctrl.sel;
    assign state = r_state;

endmodule
`default_nettype wire
